// File: rtl/riu_wr_if_iodelay_if.sv
// Command and RIU bus bundle for the RIU register write engine.
// master = command logic side, slave = write engine side.
interface riu_wr_if_iodelay_if;
    logic        valid_i;
    logic        trig_re;
    logic [5:0]  addr_i;
    logic        nib_i;
    logic [1:0]  bg_i;
    logic [15:0] wr_data_i;
    logic [15:0] riu_rd_data_bg0;
    logic [15:0] riu_rd_data_bg1;
    logic [15:0] riu_rd_data_bg2;
    logic [15:0] riu_rd_data_bg3;
    logic [5:0]  riu_addr;
    logic [1:0]  riu_nib_sel;
    logic [15:0] riu_wr_data;
    logic [3:0]  riu_wr_en_bg;
    logic        busy_o;
    logic        wr_done_o;
    logic        wr_err_o;
    logic        wr_timeout_o;
    logic [15:0] rb_data_o;

    modport master (
        output valid_i, trig_re, addr_i, nib_i, bg_i, wr_data_i,
        output riu_rd_data_bg0, riu_rd_data_bg1,
        output riu_rd_data_bg2, riu_rd_data_bg3,
        input  riu_addr, riu_nib_sel, riu_wr_data, riu_wr_en_bg,
        input  busy_o, wr_done_o, wr_err_o, wr_timeout_o, rb_data_o
    );

    modport slave (
        input  valid_i, trig_re, addr_i, nib_i, bg_i, wr_data_i,
        input  riu_rd_data_bg0, riu_rd_data_bg1,
        input  riu_rd_data_bg2, riu_rd_data_bg3,
        output riu_addr, riu_nib_sel, riu_wr_data, riu_wr_en_bg,
        output busy_o, wr_done_o, wr_err_o, wr_timeout_o, rb_data_o
    );
endinterface

// File: rtl/riu_wr_if_iodelay.sv
// RIU register write engine: wait for valid, single-cycle write strobe,
// optional readback compare, done/error/timeout reporting.
module riu_wr_if_iodelay #(
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned VERIFY  = 1,
    parameter int unsigned TIMEOUT = 1000
) (
    input logic clk,
    input logic rst,
    riu_wr_if_iodelay_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, WAIT_VLD, WRITE, RB_WAIT, CHECK, DONE
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RB_LAST = 4'(RD_LAT - 1);

    state_t      state;
    logic [5:0]  addr_q;
    logic        nib_q;
    logic [1:0]  bg_q;
    logic [15:0] data_q;
    logic [15:0] to_cnt;
    logic [3:0]  rb_cnt;
    logic [15:0] rd_sel;

    always_comb begin
        rd_sel = bus.riu_rd_data_bg0;
        unique case (bg_q)
            2'd0: rd_sel = bus.riu_rd_data_bg0;
            2'd1: rd_sel = bus.riu_rd_data_bg1;
            2'd2: rd_sel = bus.riu_rd_data_bg2;
            2'd3: rd_sel = bus.riu_rd_data_bg3;
            default: rd_sel = bus.riu_rd_data_bg0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            addr_q           <= '0;
            nib_q            <= 1'b0;
            bg_q             <= '0;
            data_q           <= '0;
            to_cnt           <= '0;
            rb_cnt           <= '0;
            bus.riu_addr     <= '0;
            bus.riu_nib_sel  <= '0;
            bus.riu_wr_data  <= '0;
            bus.riu_wr_en_bg <= '0;
            bus.busy_o       <= 1'b0;
            bus.wr_done_o    <= 1'b0;
            bus.wr_err_o     <= 1'b0;
            bus.wr_timeout_o <= 1'b0;
            bus.rb_data_o    <= '0;
        end else begin
            // strobe and done are single-cycle pulses
            bus.riu_wr_en_bg <= '0;
            bus.wr_done_o    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.trig_re) begin
                        addr_q           <= bus.addr_i;
                        nib_q            <= bus.nib_i;
                        bg_q             <= bus.bg_i;
                        data_q           <= bus.wr_data_i;
                        to_cnt           <= '0;
                        bus.wr_err_o     <= 1'b0;
                        bus.wr_timeout_o <= 1'b0;
                        bus.busy_o       <= 1'b1;
                        state            <= WAIT_VLD;
                    end
                end
                WAIT_VLD: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (bus.valid_i) begin
                        bus.riu_wr_en_bg <= 4'(1) << bg_q;
                        bus.riu_addr     <= addr_q;
                        bus.riu_wr_data  <= data_q;
                        bus.riu_nib_sel  <= nib_q ? 2'b10 : 2'b01;
                        state            <= WRITE;
                    end else if (to_cnt == TO_LAST) begin
                        bus.wr_timeout_o <= 1'b1;
                        bus.wr_done_o    <= 1'b1;
                        state            <= DONE;
                    end
                end
                WRITE: begin
                    if (VERIFY != 0) begin
                        rb_cnt <= '0;
                        state  <= RB_WAIT;
                    end else begin
                        bus.riu_nib_sel <= 2'b00;
                        bus.wr_done_o   <= 1'b1;
                        state           <= DONE;
                    end
                end
                RB_WAIT: begin
                    if (rb_cnt == RB_LAST) begin
                        state <= CHECK;
                    end else begin
                        rb_cnt <= rb_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    bus.rb_data_o   <= rd_sel;
                    bus.wr_err_o    <= (rd_sel != data_q);
                    bus.riu_nib_sel <= 2'b00;
                    bus.wr_done_o   <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    bus.busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_riu_wr_if_iodelay.sv
// Directed bench: default-parameter engine plus a TIMEOUT=8, VERIFY=0 copy.
module tb_riu_wr_if_iodelay;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    riu_wr_if_iodelay_if ia ();
    riu_wr_if_iodelay_if ib ();

    riu_wr_if_iodelay dut_a (.clk(clk), .rst(rst), .bus(ia));
    riu_wr_if_iodelay #(.RD_LAT(2), .VERIFY(0), .TIMEOUT(8))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic [5:0] a, input logic n,
                           input logic [1:0] b, input logic [15:0] d);
        ia.addr_i = a;
        ia.nib_i = n;
        ia.bg_i = b;
        ia.wr_data_i = d;
    endtask

    initial begin
        int n;
        int seen;
        int dones;
        rst = 1'b1;
        ia.valid_i = 1'b0; ia.trig_re = 1'b0;
        drive_a(6'h0, 1'b0, 2'd0, 16'h0);
        ia.riu_rd_data_bg0 = '0; ia.riu_rd_data_bg1 = '0;
        ia.riu_rd_data_bg2 = '0; ia.riu_rd_data_bg3 = '0;
        ib.valid_i = 1'b0; ib.trig_re = 1'b0;
        ib.addr_i = '0; ib.nib_i = 1'b0; ib.bg_i = '0; ib.wr_data_i = '0;
        ib.riu_rd_data_bg0 = '0; ib.riu_rd_data_bg1 = '0;
        ib.riu_rd_data_bg2 = '0; ib.riu_rd_data_bg3 = '0;
        tick(); tick();
        chk("rst_addr", ia.riu_addr, 0);
        chk("rst_nib", ia.riu_nib_sel, 0);
        chk("rst_wdata", ia.riu_wr_data, 0);
        chk("rst_wren", ia.riu_wr_en_bg, 0);
        chk("rst_busy", ia.busy_o, 0);
        chk("rst_done", ia.wr_done_o, 0);
        chk("rst_err", ia.wr_err_o, 0);
        chk("rst_to", ia.wr_timeout_o, 0);
        chk("rst_rb", ia.rb_data_o, 0);
        chk("rst_b_busy", ib.busy_o, 0);
        rst = 1'b0;
        tick();

        // write bg3 upper nibble, matching readback
        ia.valid_i = 1'b1;
        drive_a(6'h10, 1'b1, 2'd3, 16'hA5A5);
        ia.riu_rd_data_bg3 = 16'hA5A5;
        ia.trig_re = 1'b1;
        tick();
        ia.trig_re = 1'b0;
        chk("t1_busy", ia.busy_o, 1);
        chk("t1_wren_n1", ia.riu_wr_en_bg, 0);
        tick();
        chk("t1_wren", ia.riu_wr_en_bg, 4'b1000);
        chk("t1_nib", ia.riu_nib_sel, 2'b10);
        chk("t1_addr", ia.riu_addr, 6'h10);
        chk("t1_wdata", ia.riu_wr_data, 16'hA5A5);
        tick();
        chk("t1_wren_off", ia.riu_wr_en_bg, 0);
        chk("t1_nib_hold", ia.riu_nib_sel, 2'b10);
        tick(); tick();
        chk("t1_done_early", ia.wr_done_o, 0);
        tick();
        chk("t1_done", ia.wr_done_o, 1);
        chk("t1_err", ia.wr_err_o, 0);
        chk("t1_rb", ia.rb_data_o, 16'hA5A5);
        chk("t1_nib_clr", ia.riu_nib_sel, 0);
        chk("t1_busy_done", ia.busy_o, 1);

        // trigger in DONE is dropped, held into IDLE it is accepted
        drive_a(6'h15, 1'b0, 2'd1, 16'h1234);
        ia.riu_rd_data_bg1 = 16'h1230;
        ia.trig_re = 1'b1;
        tick();
        chk("b2b_drop_busy", ia.busy_o, 0);
        chk("b2b_done_pulse", ia.wr_done_o, 0);
        tick();
        ia.trig_re = 1'b0;
        chk("b2b_accept", ia.busy_o, 1);
        tick();
        chk("t2_wren", ia.riu_wr_en_bg, 4'b0010);
        chk("t2_nib", ia.riu_nib_sel, 2'b01);
        chk("t2_addr", ia.riu_addr, 6'h15);
        tick();
        // second trigger in RB_WAIT must be ignored
        drive_a(6'h3F, 1'b1, 2'd2, 16'hFFFF);
        ia.trig_re = 1'b1;
        tick();
        ia.trig_re = 1'b0;
        chk("t5_addr_hold", ia.riu_addr, 6'h15);
        chk("t5_wren", ia.riu_wr_en_bg, 0);
        tick(); tick();
        chk("t2_done", ia.wr_done_o, 1);
        chk("t2_err", ia.wr_err_o, 1);
        chk("t2_rb", ia.rb_data_o, 16'h1230);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ia.wr_done_o === 1'b1) dones++;
        end
        chk("t5_extra_done", dones, 0);
        chk("t5_idle_busy", ia.busy_o, 0);
        chk("t2_err_hold", ia.wr_err_o, 1);

        // valid_i low for 20 cycles
        ia.valid_i = 1'b0;
        drive_a(6'h01, 1'b0, 2'd0, 16'h0F0F);
        ia.riu_rd_data_bg0 = 16'h0F0F;
        ia.trig_re = 1'b1;
        tick();
        ia.trig_re = 1'b0;
        chk("t3_err_clr", ia.wr_err_o, 0);
        seen = 0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ia.riu_wr_en_bg !== 4'b0000) seen++;
            if (ia.busy_o !== 1'b1) n++;
        end
        chk("t3_no_strobe", seen, 0);
        chk("t3_busy_low", n, 0);
        ia.valid_i = 1'b1;
        chk("t3_wren_pre", ia.riu_wr_en_bg, 0);
        tick();
        chk("t3_wren", ia.riu_wr_en_bg, 4'b0001);
        tick(); tick(); tick(); tick();
        chk("t3_done", ia.wr_done_o, 1);
        chk("t3_to", ia.wr_timeout_o, 0);
        chk("t3_err", ia.wr_err_o, 0);
        chk("t3_rb", ia.rb_data_o, 16'h0F0F);
        tick();

        // reset during RB_WAIT
        drive_a(6'h22, 1'b1, 2'd2, 16'hBEEF);
        ia.riu_rd_data_bg2 = 16'hBEEF;
        ia.trig_re = 1'b1;
        tick();
        ia.trig_re = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_addr", ia.riu_addr, 0);
        chk("t6_nib", ia.riu_nib_sel, 0);
        chk("t6_wdata", ia.riu_wr_data, 0);
        chk("t6_wren", ia.riu_wr_en_bg, 0);
        chk("t6_busy", ia.busy_o, 0);
        chk("t6_done", ia.wr_done_o, 0);
        chk("t6_rb", ia.rb_data_o, 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ia.wr_done_o === 1'b1) dones++;
        end
        chk("t6_no_done", dones, 0);
        ia.trig_re = 1'b1;
        tick();
        ia.trig_re = 1'b0;
        tick();
        chk("t6_wren", ia.riu_wr_en_bg, 4'b0100);
        tick(); tick(); tick(); tick();
        chk("t6_done2", ia.wr_done_o, 1);
        chk("t6_err2", ia.wr_err_o, 0);
        chk("t6_rb2", ia.rb_data_o, 16'hBEEF);

        // timeout with TIMEOUT=8
        ib.valid_i = 1'b0;
        ib.addr_i = 6'h05; ib.bg_i = 2'd2; ib.wr_data_i = 16'h00AA;
        ib.trig_re = 1'b1;
        tick();
        ib.trig_re = 1'b0;
        n = 1;
        seen = 0;
        while (ib.wr_done_o !== 1'b1 && n < 30) begin
            tick();
            n++;
            if (ib.riu_wr_en_bg !== 4'b0000) seen++;
        end
        chk("t4_latency", n, 9);
        chk("t4_to", ib.wr_timeout_o, 1);
        chk("t4_no_strobe", seen, 0);
        chk("t4_busy", ib.busy_o, 1);
        tick();

        // VERIFY=0 write path
        ib.valid_i = 1'b1;
        ib.addr_i = 6'h07; ib.nib_i = 1'b0; ib.bg_i = 2'd0;
        ib.wr_data_i = 16'h5555;
        ib.trig_re = 1'b1;
        tick();
        ib.trig_re = 1'b0;
        chk("nv_to_clr", ib.wr_timeout_o, 0);
        tick();
        chk("nv_wren", ib.riu_wr_en_bg, 4'b0001);
        chk("nv_nib", ib.riu_nib_sel, 2'b01);
        tick();
        chk("nv_done", ib.wr_done_o, 1);
        chk("nv_nib_clr", ib.riu_nib_sel, 0);
        chk("nv_rb", ib.rb_data_o, 0);
        chk("nv_err", ib.wr_err_o, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riu_wr_if_iodelay.md
Name: riu_wr_if_iodelay

Overview:
RIU register write engine for the IODELAY/bitslice control path. It is the write-side counterpart of the RIU read interface.
- On a trigger it captures address, nibble, byte group and data.
- It waits for all byte groups to report valid, then issues a single-cycle RIU write to the selected byte group.
- Optionally it reads the register back and compares the result, then reports done, error or timeout to the command logic.

Parameters:
RD_LAT, 2, cycles between end of write strobe and sampling of riu_rd_data_bgN (1..15)
VERIFY, 1, 1 = perform readback compare after write; 0 = skip readback
TIMEOUT, 1000, max cycles spent waiting for valid_i before aborting (>=1, counter width 16)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
valid_i  in  1  AND of all byte-group valid flags; RIU ready
trig_re  in  1  single-cycle pulse requesting a new register write
addr_i  in  6  RIU register address
nib_i  in  1  nibble select: 0 = lower, 1 = upper
bg_i  in  2  target byte group 0..3
wr_data_i  in  16  data to write
riu_rd_data_bg0..bg3  in  16 each  readback data from each byte group
riu_addr  out  6  RIU address
riu_nib_sel  out  2  one-hot nibble select
riu_wr_data  out  16  RIU write data
riu_wr_en_bg  out  4  one-hot per-byte-group write strobe
busy_o  out  1  high from accepted trigger through DONE
wr_done_o  out  1  one-cycle completion pulse
wr_err_o  out  1  readback mismatch flag
wr_timeout_o  out  1  valid_i wait aborted flag
rb_data_o  out  16  last readback value

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. All outputs are registered.
- Reset values: state = IDLE, and every output is 0 (riu_addr, riu_nib_sel, riu_wr_data, riu_wr_en_bg, busy_o, wr_done_o, wr_err_o, wr_timeout_o, rb_data_o).
- Reset mid-operation: abort immediately with no write strobe and no done pulse.
- States: IDLE, WAIT_VLD, WRITE, RB_WAIT, CHECK, DONE.
- IDLE:
  - trig_re=1 captures addr_i, nib_i, bg_i and wr_data_i, and clears wr_err_o, wr_timeout_o and the timeout counter.
  - Next state is WAIT_VLD and busy_o goes high.
  - trig_re is ignored in every state except IDLE.
- WAIT_VLD:
  - The timeout counter increments each cycle.
  - valid_i=1 moves to WRITE.
  - If valid_i=0 and the counter equals TIMEOUT-1, set wr_timeout_o=1, issue no write, and go to DONE.
  - If valid_i=1 arrives on the expiry cycle, the write wins.
- WRITE (exactly one cycle):
  - riu_wr_en_bg[bg] = 1; all other strobe bits are 0.
  - riu_addr and riu_wr_data take the captured values.
  - riu_nib_sel = 2'b01 if nib=0, 2'b10 if nib=1.
  - Next state: RB_WAIT if VERIFY=1, else DONE.
- RB_WAIT: lasts RD_LAT cycles. riu_addr and riu_nib_sel are held; riu_wr_en_bg = 0.
- CHECK (one cycle):
  - Sample riu_rd_data_bg[bg] into rb_data_o.
  - wr_err_o = (sample != captured data).
  - Next state is DONE.
- DONE (one cycle):
  - wr_done_o = 1.
  - riu_nib_sel returns to 00 and busy_o drops on the transition to IDLE.
- Flag holding: wr_err_o, wr_timeout_o and rb_data_o hold their values until the next accepted trigger.
- Strobe rule: riu_wr_en_bg is 0 in every state except WRITE. It never has more than one bit set.
- Latency, with trigger sampled in cycle N and valid_i already high:
  - WRITE occurs in N+2.
  - VERIFY=1: wr_done_o in N+4+RD_LAT (N+6 at default).
  - VERIFY=0: wr_done_o in N+3.
- Back-to-back: a trigger in the DONE cycle is dropped. A trigger in the cycle after DONE (IDLE) is accepted.

Test Plan:
- Reset, then trig_re with addr=0x10, nib=1, bg=3, data=0xA5A5, valid_i=1, bg3 readback=0xA5A5 -> riu_wr_en_bg=1000 in N+2, riu_nib_sel=10, riu_addr=0x10, wr_done_o in N+6, wr_err_o=0, rb_data_o=0xA5A5.
- addr=0x15, nib=0, bg=1, data=0x1234, bg1 readback=0x1230 -> riu_wr_en_bg=0010, riu_nib_sel=01, wr_done_o with wr_err_o=1, rb_data_o=0x1230.
- Trigger with valid_i low for 20 cycles then high -> no strobe until 1 cycle after valid_i rises, busy_o high throughout, wr_timeout_o=0.
- TIMEOUT=8, valid_i held low -> wr_done_o 9 cycles after trigger, wr_timeout_o=1, riu_wr_en_bg never asserted.
- Second trig_re during RB_WAIT with different addr -> ignored, riu_addr unchanged, exactly one wr_done_o.
- rst asserted in RB_WAIT -> next cycle all outputs 0, state IDLE, no wr_done_o; a following trigger completes normally.
